// File: rtl/config_pkg.sv
// config_pkg: config-bus type codes, default header magic and loader state encoding
//   CONFIG_* : tile config type field values; tile decoders import these
//   DEFAULT_MAGIC : expected header[31:16]
//   state_e : loader FSM states
package config_pkg;
  localparam logic [15:0] CONFIG_SB     = 16'd7;
  localparam logic [15:0] CONFIG_CB0    = 16'd6;
  localparam logic [15:0] CONFIG_CB1    = 16'd5;
  localparam logic [15:0] CONFIG_CLB    = 16'd4;
  localparam logic [15:0] CONFIG_IDLE   = 16'd0;
  localparam logic [15:0] DEFAULT_MAGIC = 16'hC0F1;
  typedef enum logic [2:0] {
    ST_IDLE, ST_HEADER, ST_ADDR, ST_DATA, ST_WRITE, ST_DONE, ST_ERR
  } state_e;
endpackage

// File: rtl/config_loader.sv
// config_loader: turns a header + {addr,data} word stream into held config-bus writes
//   clk, reset (async, active-low), start (load pulse)
//   in_data/in_valid/in_ready : 32-bit word stream
//   config_addr/config_data : broadcast config bus, IDLE_ADDR/0 when not writing
//   busy, done (sticky), error (sticky), writes_issued : load status
module config_loader
  import config_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [15:0] MAGIC       = DEFAULT_MAGIC,
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] writes_issued
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  state_e state_q, state_d;
  logic [15:0] remaining_q, writes_q;
  logic [31:0] addr_q, bus_addr_q, bus_data_q;
  logic [HW-1:0] hold_q;
  logic done_q, error_q;
  logic xfer, start_ok, hdr_ok, hold_end, last_rec;
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign hdr_ok   = in_data[31:16] == MAGIC;
  assign hold_end = hold_q == '0;
  assign last_rec = remaining_q == 16'd1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: state_d = start ? ST_HEADER : state_q;
      ST_HEADER: if (xfer) state_d = !hdr_ok ? ST_ERR : (in_data[15:0] == 16'd0 ? ST_DONE : ST_ADDR);
      ST_ADDR:   if (xfer) state_d = ST_DATA;
      ST_DATA:   if (xfer) state_d = ST_WRITE;
      ST_WRITE:  if (hold_end) state_d = last_rec ? ST_DONE : ST_ADDR;
      default:   state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    in_ready = state_q inside {ST_HEADER, ST_ADDR, ST_DATA};
    busy     = state_q inside {ST_HEADER, ST_ADDR, ST_DATA, ST_WRITE};
  end
  // Bus registers are loaded on the DATA transfer and cleared on the last hold
  // cycle, so the bus only ever changes on a clock edge or an async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_q <= '0;
      writes_q    <= '0;
      addr_q      <= '0;
      bus_addr_q  <= IDLE_ADDR;
      bus_data_q  <= '0;
      hold_q      <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        writes_q <= '0;
        done_q   <= 1'b0;
        error_q  <= 1'b0;
      end
      if (state_q == ST_HEADER && xfer) begin
        remaining_q <= in_data[15:0];
        error_q     <= !hdr_ok;
        done_q      <= hdr_ok && in_data[15:0] == 16'd0;
      end
      if (state_q == ST_ADDR && xfer) addr_q <= in_data;
      if (state_q == ST_DATA && xfer) begin
        bus_addr_q <= addr_q;
        bus_data_q <= in_data;
        hold_q     <= HOLD_LOAD;
      end
      if (state_q == ST_WRITE) begin
        hold_q <= hold_end ? hold_q : hold_q - HW'(1);
        if (hold_end) begin
          bus_addr_q  <= IDLE_ADDR;
          bus_data_q  <= '0;
          writes_q    <= writes_q + 16'd1;
          remaining_q <= remaining_q - 16'd1;
          done_q      <= last_rec;
        end
      end
    end
  end
  assign config_addr   = bus_addr_q;
  assign config_data   = bus_data_q;
  assign done          = done_q;
  assign error         = error_q;
  assign writes_issued = writes_q;
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: table-driven cycle vectors on a HOLD_CYCLES=1 loader plus
// hand sequences for async reset mid-write and a HOLD_CYCLES=3 random-valid load
module tb_config_loader;
  import config_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start1 = 1'b0, valid1 = 1'b0, ready1, busy1, done1, err1;
  logic [31:0] data1 = '0, addr1_o, data1_o;
  logic [15:0] wr1;
  logic start3 = 1'b0, valid3 = 1'b0, ready3, busy3, done3, err3;
  logic [31:0] data3 = '0, addr3_o, data3_o;
  logic [15:0] wr3;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb_cap = '0;
  always #5 clk = ~clk;
  config_loader #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .in_data(data1), .in_valid(valid1),
    .in_ready(ready1), .config_addr(addr1_o), .config_data(data1_o),
    .busy(busy1), .done(done1), .error(err1), .writes_issued(wr1));
  config_loader #(.HOLD_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .in_data(data3), .in_valid(valid3),
    .in_ready(ready3), .config_addr(addr3_o), .config_data(data3_o),
    .busy(busy3), .done(done3), .error(err3), .writes_issued(wr3));
  // scoreboard tile: switch-box config of tile 3
  always @(posedge clk) if (addr1_o == {CONFIG_SB, 16'd3}) sb_cap <= data1_o;
  typedef struct {
    logic st; logic v; logic [31:0] d;
    logic rdy; logic [31:0] a; logic [31:0] dat; logic bsy; logic dn; logic er; logic [15:0] w;
  } vec_t;
  vec_t tv[20];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic step1(input logic st, input logic v, input logic [31:0] d);
    start1 = st; valid1 = v; data1 = d;
    @(posedge clk); #1;
  endtask
  logic [31:0] words3[7];
  logic [31:0] exp_a[3], exp_d[3];
  initial begin
    tv[0]  = '{1, 0, 32'h0,         1, 32'h0,         32'h0,         1, 0, 0, 16'd0};
    tv[1]  = '{0, 1, 32'hC0F1_0002, 1, 32'h0,         32'h0,         1, 0, 0, 16'd0};
    tv[2]  = '{0, 1, 32'h0007_0003, 1, 32'h0,         32'h0,         1, 0, 0, 16'd0};
    tv[3]  = '{0, 1, 32'h0000_00A5, 0, 32'h0007_0003, 32'h0000_00A5, 1, 0, 0, 16'd0};
    tv[4]  = '{0, 1, 32'h0004_0001, 1, 32'h0,         32'h0,         1, 0, 0, 16'd1};
    tv[5]  = '{0, 1, 32'h0004_0001, 1, 32'h0,         32'h0,         1, 0, 0, 16'd1};
    tv[6]  = '{0, 1, 32'h0000_0002, 0, 32'h0004_0001, 32'h0000_0002, 1, 0, 0, 16'd1};
    tv[7]  = '{0, 0, 32'h0,         0, 32'h0,         32'h0,         0, 1, 0, 16'd2};
    tv[8]  = '{0, 1, 32'hDEAD_0000, 0, 32'h0,         32'h0,         0, 1, 0, 16'd2};
    tv[9]  = '{1, 0, 32'h0,         1, 32'h0,         32'h0,         1, 0, 0, 16'd0};
    tv[10] = '{0, 1, 32'hBEEF_0001, 0, 32'h0,         32'h0,         0, 0, 1, 16'd0};
    tv[11] = '{0, 1, 32'hC0F1_0000, 0, 32'h0,         32'h0,         0, 0, 1, 16'd0};
    tv[12] = '{1, 0, 32'h0,         1, 32'h0,         32'h0,         1, 0, 0, 16'd0};
    tv[13] = '{0, 1, 32'hC0F1_0000, 0, 32'h0,         32'h0,         0, 1, 0, 16'd0};
    tv[14] = '{1, 1, 32'hC0F1_0001, 1, 32'h0,         32'h0,         1, 0, 0, 16'd0};
    tv[15] = '{0, 1, 32'hC0F1_0001, 1, 32'h0,         32'h0,         1, 0, 0, 16'd0};
    tv[16] = '{1, 0, 32'h0,         1, 32'h0,         32'h0,         1, 0, 0, 16'd0};
    tv[17] = '{0, 1, 32'h0000_0009, 1, 32'h0,         32'h0,         1, 0, 0, 16'd0};
    tv[18] = '{1, 1, 32'h1234_5678, 0, 32'h0000_0009, 32'h1234_5678, 1, 0, 0, 16'd0};
    tv[19] = '{1, 0, 32'h0,         0, 32'h0,         32'h0,         0, 1, 0, 16'd1};
    words3 = '{32'hC0F1_0003, 32'h0006_0001, 32'h0000_0011, 32'h0005_0002, 32'h0000_0022,
               32'h0004_0004, 32'h0000_0033};
    exp_a = '{32'h0006_0001, 32'h0005_0002, 32'h0004_0004};
    exp_d = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
    // async reset during a write
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    step1(1, 0, 0);
    step1(0, 1, 32'hC0F1_0001);
    step1(0, 1, 32'h0007_0003);
    step1(0, 1, 32'h0000_0055);
    chk("pre_reset_bus", addr1_o, 32'h0007_0003);
    #1 reset = 1'b0;
    #1;
    chk("rst_addr", addr1_o, 32'h0);
    chk("rst_data", data1_o, 32'h0);
    chk("rst_busy", {31'b0, busy1}, 32'h0);
    chk("rst_done", {31'b0, done1}, 32'h0);
    chk("rst_ready", {31'b0, ready1}, 32'h0);
    chk("rst_writes", {16'b0, wr1}, 32'h0);
    start1 = 0; valid1 = 0; data1 = '0;
    @(negedge clk); reset = 1'b1;
    #4;
    // cycle vectors, HOLD_CYCLES=1
    for (int i = 0; i < 20; i++) begin
      step1(tv[i].st, tv[i].v, tv[i].d);
      chk($sformatf("v%0d_ready", i), {31'b0, ready1}, {31'b0, tv[i].rdy});
      chk($sformatf("v%0d_addr", i), addr1_o, tv[i].a);
      chk($sformatf("v%0d_data", i), data1_o, tv[i].dat);
      chk($sformatf("v%0d_busy", i), {31'b0, busy1}, {31'b0, tv[i].bsy});
      chk($sformatf("v%0d_done", i), {31'b0, done1}, {31'b0, tv[i].dn});
      chk($sformatf("v%0d_error", i), {31'b0, err1}, {31'b0, tv[i].er});
      chk($sformatf("v%0d_writes", i), {16'b0, wr1}, {16'b0, tv[i].w});
    end
    start1 = 0; valid1 = 0;
    chk("sb_tile3_capture", sb_cap, 32'h0000_00A5);
    // HOLD_CYCLES=3 with random in_valid
    begin
      int idx, run, nrec, cyc, ready_bad, stable_bad;
      logic r, act;
      logic [31:0] ca, cd;
      idx = 0; run = 0; nrec = 0; cyc = 0; ready_bad = 0; stable_bad = 0;
      ca = '0; cd = '0;
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      while (!done3 && cyc < 500) begin
        r = ready3;
        valid3 = (idx < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
        data3 = (idx < 7) ? words3[idx] : 32'h0;
        @(posedge clk); #1;
        cyc++;
        if (valid3 && r) idx++;
        act = addr3_o != 32'h0 || data3_o != 32'h0;
        if (act) begin
          if (ready3) ready_bad++;
          if (run == 0) begin ca = addr3_o; cd = data3_o; end
          else if (addr3_o != ca || data3_o != cd) stable_bad++;
          run++;
        end else if (run > 0) begin
          if (nrec < 3) begin
            chk($sformatf("h3_rec%0d_hold", nrec), run, 32'd3);
            chk($sformatf("h3_rec%0d_addr", nrec), ca, exp_a[nrec]);
            chk($sformatf("h3_rec%0d_data", nrec), cd, exp_d[nrec]);
          end
          nrec++;
          run = 0;
        end
      end
      valid3 = 1'b0;
      chk("h3_timeout_done", {31'b0, done3}, 32'h1);
      chk("h3_records", nrec, 32'd3);
      chk("h3_words_consumed", idx, 32'd7);
      chk("h3_writes", {16'b0, wr3}, 32'd3);
      chk("h3_ready_in_hold", ready_bad, 32'd0);
      chk("h3_bus_stable", stable_bad, 32'd0);
      chk("h3_error", {31'b0, err3}, 32'h0);
      chk("h3_busy", {31'b0, busy3}, 32'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Master end of the tile configuration bus: it turns a word stream into single-record writes on config_addr/config_data.
- Sits at the fabric top, upstream of every pe_tile_* and broadcasts to all tiles in parallel.
- Accepts 32-bit words over a valid/ready stream: one header, then N {address, data} pairs.
- Issues one config write per pair, holds it for HOLD_CYCLES, then returns the bus to an idle address that matches no tile's config_en decode.

Parameters:
- HOLD_CYCLES, 1, cycles each record is held on the bus (>=1).
- MAGIC, 16'hC0F1, required value of header[31:16].
- IDLE_ADDR, 32'h0000_0000, bus address when not writing; type field 0 is decoded by no tile.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load.
- in_data  input  32  stream word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- config_addr  output  32  [31:16] config type, [15:0] tile_id; broadcast to tiles.
- config_data  output  32  config payload.
- busy  output  1  load in progress.
- done  output  1  sticky; load completed cleanly.
- error  output  1  sticky; bad header.
- writes_issued  output  16  records written in the current/last load.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; config_addr=IDLE_ADDR; config_data=0.
  - in_ready=0, busy=0, done=0, error=0, writes_issued=0.
  - A reset mid-write removes the record from the bus immediately, so no tile sees a partial write.
- Word transfer: occurs on a rising clk edge with in_valid&&in_ready. in_ready is registered-free (decoded from state) and is 1 only in HEADER, ADDR and DATA.
- States and transitions:
  - IDLE: start -> HEADER; clears done, error, writes_issued; busy=1.
  - HEADER: on transfer, if in_data[31:16]!=MAGIC -> ERR. Otherwise latch count=in_data[15:0]; count==0 -> DONE, else -> ADDR.
  - ADDR: on transfer, latch addr_q -> DATA.
  - DATA: on transfer, latch data_q; load hold counter=HOLD_CYCLES-1 -> WRITE.
  - WRITE:
    - config_addr=addr_q, config_data=data_q, driven from registers so the bus is glitch-free. The first bus cycle is the cycle after the DATA transfer (latency 1).
    - Decrement the hold counter each cycle.
    - At 0: writes_issued+=1, remaining-=1; remaining==0 -> DONE, else -> ADDR.
    - Bus returns to IDLE_ADDR / 0 in the cycle after the last hold cycle.
    - in_ready=0 throughout WRITE (backpressure).
  - DONE: done=1, busy=0; start -> HEADER (restart).
  - ERR: error=1, busy=0, no bus activity; start -> HEADER.
- Boundary conditions:
  - start while busy (HEADER/ADDR/DATA/WRITE) is ignored.
  - in_valid low stalls indefinitely in any receive state; the bus stays idle.
  - Records are issued with any type field, including 0 and values outside 4..7, with no filtering.
  - count=16'hFFFF is supported; writes_issued wraps only if more than 65535 records, which is impossible by construction.
  - Words presented while in IDLE, DONE or ERR are not accepted (in_ready=0).
- Throughput: one record every 2+HOLD_CYCLES cycles at full in_valid.

Decomposition:
- Shared package config_pkg holds:
  - Config type constants CONFIG_SB=7, CONFIG_CB0=6, CONFIG_CB1=5, CONFIG_CLB=4, CONFIG_IDLE=0.
  - Default MAGIC.
  - State encoding: IDLE, HEADER, ADDR, DATA, WRITE, DONE, ERR.
  - Tile decoders import the type constants from this package so both ends match.
- Single flat module. The hold counter is too small to warrant a sub-module.

Test Plan:
1. Reset with reset=0 mid-WRITE (bus = {16'd7,16'd3}) -> config_addr=0, config_data=0 in the same cycle; busy=0; done=0.
2. start; stream 32'hC0F1_0002, 32'h0007_0003, 32'h0000_00A5, 32'h0004_0001, 32'h0000_0002 (HOLD_CYCLES=1) -> bus shows {0007_0003, A5} for exactly 1 cycle, then idle, then {0004_0001, 2} for 1 cycle; done=1; writes_issued=2. A scoreboard pe_tile at tile_id 3 captures SB config A5.
3. Header 32'hBEEF_0001 -> error=1 next cycle, in_ready=0, bus never leaves IDLE_ADDR; a later start followed by a valid header clears error.
4. Header 32'hC0F1_0000 -> done=1 with writes_issued=0 and no bus activity.
5. HOLD_CYCLES=3 with in_valid toggled randomly -> each record is held exactly 3 cycles; in_ready=0 during holds; no word is lost or duplicated.
6. start pulsed during ADDR -> ignored; load finishes with the original count.
